hdr_rr_arbiter: RTL and testbench

HDR_RR_ARBITER -- requirements
Module: hdr_rr_arbiter

---
 rtl/hdr_rr_arbiter.sv | 124 ++++++++++++
 tb/tb_hdr_rr_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdr_rr_arbiter.sv
// Round-robin header arbiter: picks one requesting header buffer, holds its
// header for the parser, then forwards the parser result tagged with the
// source port. Only one header is ever in flight.
//
// Handshake rule used on every interface here: a transfer happens on a rising
// edge where both valid and ready are high; valid never depends on ready of
// the same interface.
module hdr_rr_arbiter #(
    parameter int NUM_PORTS    = 4,
    parameter int HEADER_BYTES = 192,
    parameter int PORT_W       = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_PORTS-1:0]               req_valid,
    input  logic [NUM_PORTS*8*HEADER_BYTES-1:0] req_hdr_flat,
    output logic [NUM_PORTS-1:0]               req_ready,
    input  logic [NUM_PORTS-1:0]               port_en,
    output logic                               arb_hdr_valid,
    output logic [8*HEADER_BYTES-1:0]          arb_hdr_flat,
    input  logic                               arb_hdr_ready,
    input  logic                               parser_valid,
    output logic                               parser_ready,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [PORT_W-1:0]                  out_port,
    output logic [NUM_PORTS*16-1:0]            grant_cnt_flat
);

    localparam int HDR_W = 8 * HEADER_BYTES;

    typedef enum logic [1:0] {
        S_ARB   = 2'd0,
        S_OFFER = 2'd1,
        S_BUSY  = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [PORT_W-1:0]       rr_ptr;
    logic [PORT_W-1:0]       cur_port;
    logic [PORT_W-1:0]       winner;
    logic [PORT_W-1:0]       cand;
    logic [HDR_W-1:0]        hdr_reg;
    logic [NUM_PORTS*16-1:0] grant_cnt;
    logic [NUM_PORTS-1:0]    eligible;
    logic                    found;
    logic                    capture;

    // Winner search: first eligible port after the last winner, wrapping.
    always_comb begin
        eligible = req_valid & port_en;
        found    = 1'b0;
        winner   = '0;
        cand     = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = PORT_W'((int'(rr_ptr) + k) % NUM_PORTS);
            if (!found && eligible[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Next state and handshake outputs; everything is held low while in reset.
    always_comb begin
        state_next    = state;
        req_ready     = '0;
        arb_hdr_valid = 1'b0;
        parser_ready  = 1'b0;
        out_valid     = 1'b0;
        out_port      = '0;
        if (!rst) begin
            case (state)
                S_ARB: begin
                    if (found) begin
                        req_ready[winner] = 1'b1;
                        state_next        = S_OFFER;
                    end
                end
                S_OFFER: begin
                    arb_hdr_valid = 1'b1;
                    if (arb_hdr_ready) state_next = S_BUSY;
                end
                S_BUSY: begin
                    out_valid    = parser_valid;
                    parser_ready = out_ready;
                    out_port     = cur_port;
                    if (parser_valid && out_ready) state_next = S_ARB;
                end
                default: state_next = S_ARB;
            endcase
        end
    end

    assign capture = (state == S_ARB) && found && !rst;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_ARB;
        else     state <= state_next;
    end

    // Capture of the winning header, pointer update and grant counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= PORT_W'(NUM_PORTS - 1);
            cur_port  <= '0;
            hdr_reg   <= '0;
            grant_cnt <= '0;
        end else if (capture) begin
            rr_ptr   <= winner;
            cur_port <= winner;
            hdr_reg  <= req_hdr_flat[int'(winner)*HDR_W +: HDR_W];
            grant_cnt[int'(winner)*16 +: 16] <= grant_cnt[int'(winner)*16 +: 16] + 16'd1;
        end
    end

    // The header register is only reloaded on a capture, so it stays stable
    // for the whole offer/parse/result sequence.
    assign arb_hdr_flat   = hdr_reg;
    assign grant_cnt_flat = grant_cnt;

endmodule

// File: tb/tb_hdr_rr_arbiter.sv
// Directed bench for hdr_rr_arbiter: a vector table of single transactions
// plus hand-written sequences for the multi-cycle corner cases.
module tb_hdr_rr_arbiter;

    localparam int NP = 4;
    localparam int HB = 192;
    localparam int PW = 2;
    localparam int HW = 8 * HB;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     req_valid;
    logic [NP*HW-1:0]  req_hdr_flat;
    logic [NP-1:0]     req_ready;
    logic [NP-1:0]     port_en;
    logic              arb_hdr_valid;
    logic [HW-1:0]     arb_hdr_flat;
    logic              arb_hdr_ready;
    logic              parser_valid;
    logic              parser_ready;
    logic              out_valid;
    logic              out_ready;
    logic [PW-1:0]     out_port;
    logic [NP*16-1:0]  grant_cnt_flat;

    logic [HW-1:0]     hdr_pat [NP];
    logic [15:0]       m_cnt [NP];
    int                n_checks = 0;
    int                n_fail   = 0;

    typedef struct {
        logic [NP-1:0] valid;
        logic [NP-1:0] en;
        int            exp_port;
    } vec_t;

    vec_t vecs [21];

    hdr_rr_arbiter #(.NUM_PORTS(NP), .HEADER_BYTES(HB), .PORT_W(PW)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_hdr_flat  (req_hdr_flat),
        .req_ready     (req_ready),
        .port_en       (port_en),
        .arb_hdr_valid (arb_hdr_valid),
        .arb_hdr_flat  (arb_hdr_flat),
        .arb_hdr_ready (arb_hdr_ready),
        .parser_valid  (parser_valid),
        .parser_ready  (parser_ready),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_port      (out_port),
        .grant_cnt_flat(grant_cnt_flat)
    );

    // Clock.
    always #5 clk = ~clk;

    // Requester header buses.
    always_comb begin
        req_hdr_flat = '0;
        for (int i = 0; i < NP; i++) req_hdr_flat[i*HW +: HW] = hdr_pat[i];
    end

    // Hang guard.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic rand_hdr(input int p, input logic [7:0] b0);
        for (int w = 0; w < HW / 32; w++) hdr_pat[p][w*32 +: 32] = $urandom;
        hdr_pat[p][7:0] = b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req_ready"},     64'(req_ready), 64'd0);
        check({tag, "_arb_hdr_valid"}, 64'(arb_hdr_valid), 64'd0);
        check({tag, "_parser_ready"},  64'(parser_ready), 64'd0);
        check({tag, "_out_valid"},     64'(out_valid), 64'd0);
        check({tag, "_out_port"},      64'(out_port), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '1; port_en = '1;
        arb_hdr_ready = 1'b1; parser_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("in_rst");
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0; arb_hdr_ready = 1'b0; parser_valid = 1'b0; out_ready = 1'b0;
        #1;
        check_idle_outputs("post_rst");
        check("post_rst_cnt", grant_cnt_flat, 64'd0);
        for (int i = 0; i < NP; i++) m_cnt[i] = '0;
    endtask

    // One full transaction with immediate parser handshakes. Called at a
    // falling edge with the DUT in S_ARB; returns at a falling edge in S_ARB.
    task automatic run_txn(input logic [NP-1:0] v, input logic [NP-1:0] en,
                           input int exp_port, input string tag);
        logic [HW-1:0] exp_hdr;
        logic [NP-1:0] exp_rdy;
        req_valid = v; port_en = en;
        arb_hdr_ready = 1'b0; parser_valid = 1'b0; out_ready = 1'b0;
        exp_rdy = '0;
        if (exp_port >= 0) exp_rdy[exp_port] = 1'b1;
        #1;
        check({tag, "_req_ready"}, 64'(req_ready), 64'(exp_rdy));
        if (exp_port < 0) begin
            @(negedge clk);
            #1;
            check({tag, "_no_offer"}, 64'(arb_hdr_valid), 64'd0);
            req_valid = '0; port_en = '1;
        end else begin
            exp_hdr = hdr_pat[exp_port];
            @(negedge clk);
            req_valid = '0; port_en = '0;
            rand_hdr(exp_port, 8'hA0 + 8'(exp_port));
            #1;
            check({tag, "_offer"},       64'(arb_hdr_valid), 64'd1);
            check({tag, "_ready_pulse"}, 64'(req_ready), 64'd0);
            check({tag, "_hdr"},         64'(arb_hdr_flat == exp_hdr), 64'd1);
            arb_hdr_ready = 1'b1;
            @(negedge clk);
            arb_hdr_ready = 1'b0;
            #1;
            check({tag, "_offer_drop"},  64'(arb_hdr_valid), 64'd0);
            check({tag, "_no_result"},   64'(out_valid), 64'd0);
            parser_valid = 1'b1; out_ready = 1'b1;
            #1;
            check({tag, "_out_valid"},    64'(out_valid), 64'd1);
            check({tag, "_parser_ready"}, 64'(parser_ready), 64'd1);
            check({tag, "_out_port"},     64'(out_port), 64'(exp_port));
            check({tag, "_hdr_hold"},     64'(arb_hdr_flat == exp_hdr), 64'd1);
            @(negedge clk);
            parser_valid = 1'b0; out_ready = 1'b0; port_en = '1;
            m_cnt[exp_port] = m_cnt[exp_port] + 16'd1;
            #1;
            check({tag, "_cnt"}, 64'(grant_cnt_flat[exp_port*16 +: 16]), 64'(m_cnt[exp_port]));
            check({tag, "_done"}, 64'(out_valid), 64'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < NP; i++) rand_hdr(i, 8'hA0 + 8'(i));

        // Table: {req_valid, port_en, expected winner (-1 = none)}.
        vecs[0]  = '{4'b1111, 4'b1111, 0};
        vecs[1]  = '{4'b1111, 4'b1111, 1};
        vecs[2]  = '{4'b1111, 4'b1111, 2};
        vecs[3]  = '{4'b1111, 4'b1111, 3};
        vecs[4]  = '{4'b1111, 4'b1111, 0};
        vecs[5]  = '{4'b1111, 4'b1111, 1};
        vecs[6]  = '{4'b1111, 4'b1111, 2};
        vecs[7]  = '{4'b1111, 4'b1111, 3};
        vecs[8]  = '{4'b1111, 4'b1011, 0};
        vecs[9]  = '{4'b1111, 4'b1011, 1};
        vecs[10] = '{4'b1111, 4'b1011, 3};
        vecs[11] = '{4'b1111, 4'b1011, 0};
        vecs[12] = '{4'b0010, 4'b1111, 1};
        vecs[13] = '{4'b1001, 4'b1111, 3};
        vecs[14] = '{4'b0001, 4'b1111, 0};
        vecs[15] = '{4'b0001, 4'b1111, 0};
        vecs[16] = '{4'b0110, 4'b0100, 2};
        vecs[17] = '{4'b0000, 4'b1111, -1};
        vecs[18] = '{4'b1111, 4'b0000, -1};
        vecs[19] = '{4'b0101, 4'b1111, 0};
        vecs[20] = '{4'b1100, 4'b1111, 2};

        // Single requester with a slow parser.
        do_reset();
        hdr_pat[2][7:0] = 8'hAA;
        req_valid = 4'b0100;
        #1;
        check("single_req_ready", 64'(req_ready), 64'b0100);
        @(negedge clk);
        #1;
        check("single_req_ready_once", 64'(req_ready), 64'd0);
        check("single_offer", 64'(arb_hdr_valid), 64'd1);
        check("single_byte0", 64'(arb_hdr_flat[7:0]), 64'hAA);
        req_valid = '0;
        @(negedge clk);
        #1;
        check("single_offer_wait", 64'(arb_hdr_valid), 64'd1);
        arb_hdr_ready = 1'b1;
        @(negedge clk);
        arb_hdr_ready = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("single_wait_out_valid", 64'(out_valid), 64'd0);
            check("single_wait_parser_ready", 64'(parser_ready), 64'd1);
            @(negedge clk);
        end
        parser_valid = 1'b1;
        #1;
        check("single_out_valid", 64'(out_valid), 64'd1);
        check("single_out_port", 64'(out_port), 64'd2);
        check("single_byte0_hold", 64'(arb_hdr_flat[7:0]), 64'hAA);
        @(negedge clk);
        parser_valid = 1'b0; out_ready = 1'b0;
        #1;
        check("single_cnt2", 64'(grant_cnt_flat[2*16 +: 16]), 64'd1);
        check("single_idle", 64'(out_valid), 64'd0);
        rand_hdr(2, 8'hA2);

        // Vector table.
        do_reset();
        for (int i = 0; i < 21; i++) begin
            run_txn(vecs[i].valid, vecs[i].en, vecs[i].exp_port, $sformatf("vec%0d", i));
            if (i == 7) begin
                for (int p = 0; p < NP; p++)
                    check($sformatf("rr8_cnt%0d", p), 64'(grant_cnt_flat[p*16 +: 16]), 64'd2);
            end
        end
        for (int p = 0; p < NP; p++)
            check($sformatf("table_cnt%0d", p), 64'(grant_cnt_flat[p*16 +: 16]), 64'(m_cnt[p]));

        // Result backpressure: last winner was port 2, so port 3 wins now.
        begin
            logic [HW-1:0] held;
            req_valid = 4'b1111; port_en = 4'b1111;
            held = hdr_pat[3];
            #1;
            check("bp_req_ready", 64'(req_ready), 64'b1000);
            @(negedge clk);
            rand_hdr(3, 8'h5C);
            arb_hdr_ready = 1'b1;
            @(negedge clk);
            arb_hdr_ready = 1'b0; port_en = '0;
            parser_valid = 1'b1; out_ready = 1'b0;
            for (int c = 0; c < 10; c++) begin
                #1;
                check("bp_out_valid", 64'(out_valid), 64'd1);
                check("bp_parser_ready", 64'(parser_ready), 64'd0);
                check("bp_no_req_ready", 64'(req_ready), 64'd0);
                check("bp_hdr_stable", 64'(arb_hdr_flat == held), 64'd1);
                if (c == 5) req_valid = '0;
                @(negedge clk);
            end
            out_ready = 1'b1;
            #1;
            check("bp_release_parser_ready", 64'(parser_ready), 64'd1);
            check("bp_out_port", 64'(out_port), 64'd3);
            @(negedge clk);
            parser_valid = 1'b0; out_ready = 1'b0; port_en = '1;
            m_cnt[3] = m_cnt[3] + 16'd1;
            #1;
            check("bp_cnt3", 64'(grant_cnt_flat[3*16 +: 16]), 64'(m_cnt[3]));
            rand_hdr(3, 8'hA3);
        end

        // Reset while the parser result is pending.
        do_reset();
        req_valid = 4'b0010;
        @(negedge clk);
        req_valid = '0; arb_hdr_ready = 1'b1;
        @(negedge clk);
        arb_hdr_ready = 1'b0; parser_valid = 1'b1; out_ready = 1'b0;
        #1;
        check("mid_rst_busy", 64'(out_valid), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        #1;
        check_idle_outputs("mid_rst_after");
        check("mid_rst_cnt", grant_cnt_flat, 64'd0);
        @(negedge clk);
        #1;
        check("mid_rst_no_forward", 64'(out_valid), 64'd0);
        parser_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < NP; i++) m_cnt[i] = '0;
        run_txn(4'b1000, 4'b1111, 3, "mid_rst_next");

        // Grant counter wrap; the preceding 65535 grants are preloaded.
        do_reset();
        force dut.grant_cnt = 64'h0000_0000_0000_FFFF;
        #1;
        release dut.grant_cnt;
        #1;
        check("wrap_preload", 64'(grant_cnt_flat[15:0]), 64'hFFFF);
        m_cnt[0] = 16'hFFFF;
        run_txn(4'b0001, 4'b1111, 0, "wrap");
        check("wrap_cnt0", 64'(grant_cnt_flat[15:0]), 64'd0);
        check("wrap_others", 64'(grant_cnt_flat[NP*16-1:16]), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
